// File: rtl/fib_pkg.sv
// Shared constants and state type for the Fibonacci stream checker.
package fib_pkg;

    localparam int W_DEFAULT = 16;  // default width of one number
    localparam int LANES_MAX = 2;   // widest beat supported (double-rate generator)

    // One sub-state per window fill: nothing held, one value held, full window.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        TRACK = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_lane_check.sv
// Single-lane Fibonacci rule check: x must equal a + b modulo 2^W.
module fib_lane_check #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] x_i,
    output logic         pass_o
);

    logic [W-1:0] sum;

    // The sum is kept W bits wide so the carry drops out, matching generator wrap.
    assign sum    = a_i + b_i;
    assign pass_o = (sum == x_i);

endmodule

// File: rtl/fibonacci_checker.sv
// Sink-side monitor for Fibonacci generator streams. Keeps a two-value window of
// the last received numbers, checks every new number against the window sum,
// and reports mismatch pulses, lock status and a saturating error count.
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int LANES    = 1,
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_num,
    output logic               mismatch,
    output logic               locked,
    output logic [CNT_W-1:0]   err_count,
    output logic [W-1:0]       expected
);

    localparam int PW    = LANES_MAX * W;
    // Room for LOCK_LEN plus one beat of increments before saturation is applied.
    localparam int RUN_W = $clog2(LOCK_LEN + LANES_MAX + 1);

    fib_state_e       state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [W-1:0]     cur_q, cur_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             mismatch_q, mismatch_d;
    logic             locked_q, locked_d;
    logic [W-1:0]     expected_q;
    logic             ready_q;

    logic [PW-1:0]    num_pad;
    logic [W-1:0]     rx0, rx1;
    logic             pass0, pass1;
    logic             accept;
    logic [1:0]       fail_cnt, pass_cnt;
    logic [RUN_W-1:0] run_sum;
    logic [CNT_W:0]   err_sum;

    // Widen the beat to the two-lane layout; lane1 reads as zero in single-lane builds.
    assign num_pad = PW'(in_num);
    assign rx0     = num_pad[W-1:0];
    assign rx1     = num_pad[PW-1:W];

    // Clear has priority over a beat: the beat is refused rather than half-applied.
    assign in_ready = ready_q && !clear;
    assign accept   = in_valid && in_ready;

    // Lane1 compares against the received lane0, not the predicted one, so a bad
    // lane0 does not automatically fail lane1 as well. Idle when LANES == 1.
    fib_lane_check #(.W(W)) u_lane0 (.a_i(prev_q), .b_i(cur_q), .x_i(rx0), .pass_o(pass0));
    fib_lane_check #(.W(W)) u_lane1 (.a_i(cur_q),  .b_i(rx0),   .x_i(rx1), .pass_o(pass1));

    // Next-state: window fill sequencing, per-beat check results, run and error counters.
    always_comb begin
        // NOTE: every variable gets a default first; a path that skipped one would infer a latch.
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        run_d      = run_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        fail_cnt   = '0;
        pass_cnt   = '0;
        run_sum    = '0;
        err_sum    = '0;

        if (clear) begin
            state_d = EMPTY;
            prev_d  = '0;
            cur_d   = '0;
            run_d   = '0;
            err_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                EMPTY: begin
                    if (LANES == 1) begin
                        cur_d   = rx0;
                        state_d = HALF;
                    end else begin
                        prev_d  = rx0;
                        cur_d   = rx1;
                        state_d = TRACK;
                    end
                end
                HALF: begin
                    prev_d  = cur_q;
                    cur_d   = rx0;
                    state_d = TRACK;
                end
                TRACK: begin
                    fail_cnt = {1'b0, !pass0};
                    pass_cnt = {1'b0, pass0};
                    if (LANES == 2) begin
                        fail_cnt = fail_cnt + {1'b0, !pass1};
                        pass_cnt = pass_cnt + {1'b0, pass1};
                        prev_d   = rx0;
                        cur_d    = rx1;
                    end else begin
                        prev_d   = cur_q;
                        cur_d    = rx0;
                    end

                    // Any failing lane in the beat resets the run, even if the other passed.
                    run_sum = run_q + RUN_W'(pass_cnt);
                    if (fail_cnt != 2'd0) begin
                        run_d = '0;
                    end else if (run_sum >= RUN_W'(LOCK_LEN)) begin
                        run_d = RUN_W'(LOCK_LEN);
                    end else begin
                        run_d = run_sum;
                    end

                    err_sum    = {1'b0, err_q} + (CNT_W + 1)'(fail_cnt);
                    err_d      = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                    mismatch_d = (fail_cnt != 2'd0);
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign locked_d = (run_d >= RUN_W'(LOCK_LEN));

    // State, window, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            prev_q     <= '0;
            cur_q      <= '0;
            run_q      <= '0;
            err_q      <= '0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
            expected_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            run_q      <= run_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            locked_q   <= locked_d;
            expected_q <= prev_d + cur_d;
            ready_q    <= 1'b1;
        end
    end

    assign mismatch  = mismatch_q;
    assign locked    = locked_q;
    assign err_count = err_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: one single-lane and one double-lane
// instance, driven with directed and random streams. A reference model tracks
// the last two received numbers of each stream and queues the expected outputs;
// a monitor pops and compares them the cycle after each accepted beat.
module tb_fibonacci_checker;

    typedef struct packed {
        logic        mm;
        logic        lk;
        logic [15:0] err;
        logic [15:0] ex;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr1 = 1'b0, clr2 = 1'b0;
    logic        vld1 = 1'b0, vld2 = 1'b0;
    logic [15:0] num1 = '0;
    logic [31:0] num2 = '0;
    logic        rdy1, rdy2, mm1, mm2, lk1, lk2;
    logic [15:0] err1, err2, exp1, exp2;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   up    = 1'b0;   // ready is expected from the first edge after reset release
    bit   pend [2];
    bit   cpend [2];
    exp_t q0 [$];
    exp_t q1 [$];

    // Reference model state: last two received values and counts since clear.
    logic [15:0] m_prev [2];
    logic [15:0] m_cur [2];
    int          m_n [2];
    int          m_run [2];
    int          m_err [2];

    logic [15:0] ga, gb;  // stimulus generator pair

    always #5 clk = ~clk;

    fibonacci_checker #(.W(16), .LANES(1), .LOCK_LEN(4), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clr1), .in_valid(vld1), .in_ready(rdy1),
        .in_num(num1), .mismatch(mm1), .locked(lk1), .err_count(err1), .expected(exp1)
    );

    fibonacci_checker #(.W(16), .LANES(2), .LOCK_LEN(4), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clr2), .in_valid(vld2), .in_ready(rdy2),
        .in_num(num2), .mismatch(mm2), .locked(lk2), .err_count(err2), .expected(exp2)
    );

    task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL L%0d %s: got %0d, expected %0d (t=%0t)", d + 1, name, act, req, $time);
        end
    endtask

    task automatic model_clear(input int d);
        m_prev[d] = '0;
        m_cur[d]  = '0;
        m_n[d]    = 0;
        m_run[d]  = 0;
        m_err[d]  = 0;
    endtask

    // Every value from the third one after clear must equal the sum of the two before it.
    task automatic model_beat(input int d, input logic [15:0] v0, input logic [15:0] v1, input int nl);
        int          fails;
        logic [15:0] v, sum;
        exp_t        e;
        fails = 0;
        for (int i = 0; i < nl; i++) begin
            v   = (i == 0) ? v0 : v1;
            sum = m_prev[d] + m_cur[d];
            if (m_n[d] >= 2) begin
                if (v == sum) m_run[d]++;
                else          fails++;
            end
            m_prev[d] = m_cur[d];
            m_cur[d]  = v;
            m_n[d]++;
        end
        if (fails > 0) m_run[d] = 0;
        m_err[d] = (m_err[d] + fails > 65535) ? 65535 : m_err[d] + fails;
        e.mm  = (fails > 0);
        e.lk  = (m_run[d] >= 4);
        e.err = 16'(m_err[d]);
        e.ex  = m_prev[d] + m_cur[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [15:0] v);
        vld1 = 1'b1;
        num1 = v;
        model_beat(0, v, 16'd0, 1);
        tick();
        vld1 = 1'b0;
    endtask

    task automatic send2(input logic [15:0] a, input logic [15:0] b);
        vld2 = 1'b1;
        num2 = {b, a};
        model_beat(1, a, b, 2);
        tick();
        vld2 = 1'b0;
    endtask

    // Clear, optionally with a beat offered in the same cycle (it must be dropped).
    task automatic clear_dut(input int d, input bit with_valid);
        if (d == 0) begin
            clr1 = 1'b1; vld1 = with_valid; num1 = 16'($urandom);
        end else begin
            clr2 = 1'b1; vld2 = with_valid; num2 = $urandom;
        end
        model_clear(d);
        tick();
        clr1 = 1'b0; clr2 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up  = 1'b0;
        model_clear(0);
        model_clear(1);
        q0.delete();
        q1.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        up = 1'b1;
    endtask

    task automatic gen_seed();
        ga = 16'($urandom);
        gb = 16'($urandom);
    endtask

    task automatic gen_next(output logic [15:0] v);
        logic [15:0] t;
        v  = ga;
        t  = ga + gb;
        ga = gb;
        gb = t;
    endtask

    task automatic mon_dut(input int d, input logic rdy, input logic mm, input logic lk,
                           input logic [15:0] er, input logic [15:0] ex,
                           input logic vl, input logic cl);
        exp_t e;
        if (rst) begin
            check(d, "reset in_ready", rdy, 0);
            check(d, "reset mismatch", mm, 0);
            check(d, "reset locked", lk, 0);
            check(d, "reset err_count", er, 0);
            check(d, "reset expected", ex, 0);
            pend[d]  = 1'b0;
            cpend[d] = 1'b0;
            return;
        end
        check(d, "in_ready", rdy, up && !cl);
        if (pend[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL L%0d scoreboard: beat accepted with no expected entry (t=%0t)", d + 1, $time);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check(d, "mismatch", mm, e.mm);
                check(d, "locked", lk, e.lk);
                check(d, "err_count", er, e.err);
                check(d, "expected", ex, e.ex);
            end
        end else if (cpend[d]) begin
            check(d, "clear mismatch", mm, 0);
            check(d, "clear locked", lk, 0);
            check(d, "clear err_count", er, 0);
            check(d, "clear expected", ex, 0);
        end else begin
            check(d, "idle mismatch", mm, 0);
        end
        pend[d]  = vl && rdy;
        cpend[d] = cl;
    endtask

    // Monitor: compares outputs on the falling edge, away from the active edge.
    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0; cpend[0] = 1'b0; cpend[1] = 1'b0;
        forever begin
            @(negedge clk);
            mon_dut(0, rdy1, mm1, lk1, err1, exp1, vld1, clr1);
            mon_dut(1, rdy2, mm2, lk2, err2, exp2, vld2, clr2);
        end
    end

    // Bound on total run time.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        logic [15:0] v, a, b;
        int          r;
        logic [15:0] seq_a [7] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
        logic [15:0] seq_b [7] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd7, 16'd10, 16'd17};

        model_clear(0);
        model_clear(1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        up = 1'b1;
        tick();

        // Single lane: clean run, lock after the fourth checked value.
        foreach (seq_a[i]) send1(seq_a[i]);
        tick();
        clear_dut(0, 1'b0);
        // Single bad value; the window resyncs so the following values pass.
        foreach (seq_b[i]) send1(seq_b[i]);
        tick();
        clear_dut(0, 1'b0);
        // Modulo wrap: 28657 + 46368 = 75025 -> 9489.
        send1(16'd28657);
        send1(16'd46368);
        send1(16'd9489);
        send1(16'd55857);
        // Reset in the middle of a stream, then resume.
        send1(16'd1);
        do_reset();
        send1(16'd2);
        send1(16'd3);
        send1(16'd5);

        // Single lane random: fresh sequences, corrupted values, idles, clears.
        clear_dut(0, 1'b1);
        gen_seed();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                tick();
            end else if (r < 11) begin
                clear_dut(0, 1'($urandom_range(0, 1)));
                gen_seed();
            end else if (r < 20) begin
                gen_next(v);
                send1(16'($urandom));
            end else begin
                gen_next(v);
                send1(v);
            end
        end
        tick();

        // Double lane: clean pairs, lock after the third beat.
        send2(16'd1, 16'd1);
        send2(16'd2, 16'd3);
        send2(16'd5, 16'd8);
        send2(16'd13, 16'd21);
        tick();
        clear_dut(1, 1'b0);
        // Both lanes of one beat wrong: two errors, one pulse.
        send2(16'd1, 16'd1);
        send2(16'd4, 16'd9);
        send2(16'd13, 16'd22);
        // Clear with a beat offered mid-TRACK: beat dropped.
        clear_dut(1, 1'b1);
        send2(16'd7, 16'd7);
        send2(16'd14, 16'd21);

        // Double lane random.
        clear_dut(1, 1'b0);
        gen_seed();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                tick();
            end else if (r < 11) begin
                clear_dut(1, 1'($urandom_range(0, 1)));
                gen_seed();
            end else begin
                gen_next(a);
                gen_next(b);
                if (r < 16)      a = 16'($urandom);
                else if (r < 21) b = 16'($urandom);
                send2(a, b);
            end
        end

        tick();
        tick();
        check(0, "scoreboard drained", q0.size(), 0);
        check(1, "scoreboard drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
